derivative_term_sequencer: RTL and testbench



---
 rtl/deriv_pkg.sv | 28 ++
 rtl/derivative_term_sequencer_if.sv | 30 +++
 rtl/deriv_term_fifo.sv | 54 +++++
 rtl/derivative_term_sequencer.sv | 115 +++++++++++
 tb/tb_derivative_term_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/deriv_pkg.sv
// Shared widths, term record and sequencer states for the derivative term path.
package deriv_pkg;

   localparam int unsigned COEF_W = 4;
   localparam int unsigned EXP_W  = 4;
   localparam int unsigned PROD_W = COEF_W + EXP_W;

   typedef struct packed {
      logic [PROD_W-1:0] coef;
      logic [EXP_W-1:0]  exp;
   } deriv_term_t;

   typedef enum logic [1:0] {
      COLLECT,
      EMIT,
      ZERO
   } seq_state_t;

   // d/dx (c * x^e) = (c*e) * x^(e-1)
   function automatic deriv_term_t derive(input logic [COEF_W-1:0] c,
                                          input logic [EXP_W-1:0]  e);
      deriv_term_t t;
      t.coef = PROD_W'(c) * PROD_W'(e);
      t.exp  = e - EXP_W'(1);
      return t;
   endfunction

endpackage

// File: rtl/derivative_term_sequencer_if.sv
// Input term stream, output derivative stream and status flags of the sequencer.
interface derivative_term_sequencer_if;

   logic                          in_valid;
   logic                          in_ready;
   logic [deriv_pkg::COEF_W-1:0]  in_coef;
   logic [deriv_pkg::EXP_W-1:0]   in_exp;
   logic                          in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [deriv_pkg::PROD_W-1:0]  out_coef;
   logic [deriv_pkg::EXP_W-1:0]   out_exp;
   logic                          out_last;
   logic                          out_zero;
   logic                          err_overflow;
   logic                          busy;

   modport slave (
      input  in_valid, in_coef, in_exp, in_last, out_ready,
      output in_ready, out_valid, out_coef, out_exp, out_last, out_zero,
             err_overflow, busy
   );

   modport master (
      output in_valid, in_coef, in_exp, in_last, out_ready,
      input  in_ready, out_valid, out_coef, out_exp, out_last, out_zero,
             err_overflow, busy
   );

endinterface

// File: rtl/deriv_term_fifo.sv
// Synchronous FIFO of derivative terms; pointers wrap modulo DEPTH (power of 2).
module deriv_term_fifo
   import deriv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  deriv_term_t      din,
   input  logic             pop,
   output deriv_term_t      head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   deriv_term_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/derivative_term_sequencer.sv
// Collects one polynomial's non-zero derivative terms, then replays them
// (or a single zero term) over the output handshake.
module derivative_term_sequencer
   import deriv_pkg::*;
#(
   parameter int unsigned TERM_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   derivative_term_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(TERM_DEPTH) + 1;

   seq_state_t       state;
   seq_state_t       state_next;
   deriv_term_t      term;
   deriv_term_t      head;
   logic             in_acc;
   logic             kept;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             err_q;
   logic             out_valid_c;
   logic             out_last_c;
   logic             out_zero_c;
   logic [PROD_W-1:0] out_coef_c;
   logic [EXP_W-1:0]  out_exp_c;

   assign term   = derive(bus.in_coef, bus.in_exp);
   assign in_acc = bus.in_valid && (state == COLLECT);
   assign kept   = in_acc && (bus.in_coef != '0) && (bus.in_exp != '0);
   assign push   = kept && !fifo_full;
   assign pop    = (state == EMIT) && bus.out_ready;

   deriv_term_fifo #(
      .DEPTH (TERM_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (term),
      .pop   (pop),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      out_valid_c = 1'b0;
      out_coef_c  = '0;
      out_exp_c   = '0;
      out_last_c  = 1'b0;
      out_zero_c  = 1'b0;
      unique case (state)
         COLLECT: begin
            // ZERO only when nothing is buffered and this last term is not pushed either
            if (in_acc && bus.in_last) begin
               state_next = (fifo_empty && !push) ? ZERO : EMIT;
            end
         end
         EMIT: begin
            out_valid_c = 1'b1;
            out_coef_c  = head.coef;
            out_exp_c   = head.exp;
            out_last_c  = (fifo_count == CNT_W'(1));
            if (bus.out_ready && out_last_c) begin
               state_next = COLLECT;
            end
         end
         ZERO: begin
            out_valid_c = 1'b1;
            out_last_c  = 1'b1;
            out_zero_c  = 1'b1;
            if (bus.out_ready) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (kept && fifo_full) begin
         err_q <= 1'b1;
      end else if (out_valid_c && bus.out_ready && out_last_c) begin
         err_q <= 1'b0;
      end
   end

   assign bus.in_ready     = (state == COLLECT);
   assign bus.out_valid    = out_valid_c;
   assign bus.out_coef     = out_coef_c;
   assign bus.out_exp      = out_exp_c;
   assign bus.out_last     = out_last_c;
   assign bus.out_zero     = out_zero_c;
   assign bus.err_overflow = err_q;
   assign bus.busy         = (state != COLLECT);

endmodule

// File: tb/tb_derivative_term_sequencer.sv
// Directed bench for derivative_term_sequencer with a queue-based frame model.
module tb_derivative_term_sequencer;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   derivative_term_sequencer_if b ();

   derivative_term_sequencer #(
      .TERM_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int coef;
      int exp;
      bit last;
      bit zero;
   } term_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
      end
   endtask

   // Frame model: queue of derivative terms still owed to the consumer
   term_t mq[$];
   bit    m_busy = 1'b0;
   bit    m_ovf  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_busy = 1'b0;
         m_ovf  = 1'b0;
      end else if (!m_busy) begin
         if (b.in_valid) begin
            if (b.in_coef != 0 && b.in_exp != 0) begin
               if (mq.size() < DEPTH)
                  mq.push_back('{int'(b.in_coef) * int'(b.in_exp), int'(b.in_exp) - 1, 1'b0, 1'b0});
               else
                  m_ovf = 1'b1;
            end
            if (b.in_last) begin
               if (mq.size() == 0) mq.push_back('{0, 0, 1'b0, 1'b1});
               m_busy = 1'b1;
            end
         end
      end else if (b.out_ready) begin
         void'(mq.pop_front());
         if (mq.size() == 0) begin
            m_busy = 1'b0;
            m_ovf  = 1'b0;
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", int'(b.in_ready), int'(!m_busy));
         check("out_valid", int'(b.out_valid), int'(m_busy));
         check("busy", int'(b.busy), int'(m_busy));
         check("err_overflow", int'(b.err_overflow), int'(m_ovf));
         if (m_busy && mq.size() > 0) begin
            check("out_coef", int'(b.out_coef), mq[0].coef);
            check("out_exp", int'(b.out_exp), mq[0].exp);
            check("out_last", int'(b.out_last), int'(mq.size() == 1));
            check("out_zero", int'(b.out_zero), int'(mq[0].zero));
         end
      end
   end

   // Observed output transfers (inputs change only just after posedge)
   term_t obs[$];
   always @(negedge clk) begin
      if (rst_n && b.out_valid && b.out_ready)
         obs.push_back('{int'(b.out_coef), int'(b.out_exp), b.out_last, b.out_zero});
   end

   task automatic send(input int c, input int e, input bit l);
      b.in_coef  = 4'(c);
      b.in_exp   = 4'(e);
      b.in_last  = l;
      b.in_valid = 1'b1;
      @(posedge clk);
      #1;
      b.in_valid = 1'b0;
      b.in_last  = 1'b0;
   endtask

   task automatic wait_last();
      bit got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (obs.size() > 0 && obs[$].last) got = 1'b1;
      end
      @(posedge clk);
      #1;
      check("frame_done", int'(got), 1);
   endtask

   task automatic check_obs(input string name, input int idx, input int c, input int e,
                            input bit l, input bit z);
      if (obs.size() <= idx) begin
         check({name, "_present"}, obs.size(), idx + 1);
      end else begin
         check({name, "_coef"}, obs[idx].coef, c);
         check({name, "_exp"}, obs[idx].exp, e);
         check({name, "_last"}, int'(obs[idx].last), int'(l));
         check({name, "_zero"}, int'(obs[idx].zero), int'(z));
      end
   endtask

   initial begin
      b.in_valid  = 1'b0;
      b.in_coef   = '0;
      b.in_exp    = '0;
      b.in_last   = 1'b0;
      b.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", int'(b.in_ready), 1);
      check("rst_out_valid", int'(b.out_valid), 0);
      check("rst_out_coef", int'(b.out_coef), 0);
      check("rst_out_exp", int'(b.out_exp), 0);
      check("rst_out_last", int'(b.out_last), 0);
      check("rst_out_zero", int'(b.out_zero), 0);
      check("rst_err", int'(b.err_overflow), 0);
      check("rst_busy", int'(b.busy), 0);
      rst_n = 1'b1;

      // 3x^2+5x+7 -> 6x + 5
      obs.delete();
      b.out_ready = 1'b1;
      send(3, 2, 0); send(5, 1, 0); send(7, 0, 1);
      wait_last();
      check("poly_count", obs.size(), 2);
      check_obs("poly0", 0, 6, 1, 0, 0);
      check_obs("poly1", 1, 5, 0, 1, 0);

      // Constant only -> single zero derivative term
      obs.delete();
      send(7, 0, 1);
      wait_last();
      check("const_count", obs.size(), 1);
      check_obs("const0", 0, 0, 0, 1, 1);
      check("const_ready_after", int'(b.in_ready), 1);

      // Overflow: fifth kept term discarded
      obs.delete();
      b.out_ready = 1'b0;
      send(1, 1, 0); send(1, 2, 0); send(1, 3, 0); send(1, 4, 0); send(1, 5, 1);
      check("ovf_err_emit", int'(b.err_overflow), 1);
      b.out_ready = 1'b1;
      wait_last();
      check("ovf_count", obs.size(), 4);
      check_obs("ovf0", 0, 1, 0, 0, 0);
      check_obs("ovf1", 1, 2, 1, 0, 0);
      check_obs("ovf2", 2, 3, 2, 0, 0);
      check_obs("ovf3", 3, 4, 3, 1, 0);
      check("ovf_err_after", int'(b.err_overflow), 0);

      // Extremes plus a zero coefficient
      obs.delete();
      send(0, 9, 0); send(15, 15, 1);
      wait_last();
      check("ext_count", obs.size(), 1);
      check_obs("ext0", 0, 225, 14, 1, 0);

      // Backpressure during EMIT
      obs.delete();
      b.out_ready = 1'b0;
      send(3, 2, 0); send(5, 1, 0); send(7, 0, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", int'(b.out_valid), 1);
         check("bp_coef", int'(b.out_coef), 6);
         check("bp_exp", int'(b.out_exp), 1);
      end
      @(posedge clk);
      #1;
      b.out_ready = 1'b1;
      wait_last();
      check("bp_count", obs.size(), 2);
      check_obs("bp0", 0, 6, 1, 0, 0);
      check_obs("bp1", 1, 5, 0, 1, 0);

      // Reset mid-EMIT after one output transfer
      obs.delete();
      b.out_ready = 1'b0;
      send(3, 2, 0); send(5, 1, 0); send(7, 0, 1);
      b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      b.out_ready = 1'b0;
      check("rm_first_xfer", obs.size(), 1);
      rst_n = 1'b0;
      #1;
      check("rm_out_valid", int'(b.out_valid), 0);
      check("rm_busy", int'(b.busy), 0);
      check("rm_in_ready", int'(b.in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      obs.delete();
      b.out_ready = 1'b1;
      send(2, 3, 1);
      wait_last();
      check("rm_count", obs.size(), 1);
      check_obs("rm0", 0, 6, 2, 1, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
